// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: writes a table of {reg_addr, reg_data} pairs into a 7-bit I2C
// slave through a Wishbone i2c_master_top core (PRER/CTR/TXR/RXR/CR/SR map).
// Optionally reads every entry back and compares it, retries an entry after a
// NACK or a read-back mismatch, and reports the entry and cause of an abort.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, verify_en   pass request pulse; read-back enable sampled with start
//   rom_addr/rom_data  table index out, table word in (1-cycle read latency)
//   wb_*               Wishbone master to the I2C core (stb doubles as cyc)
//   busy, done         pass/INIT in progress; one-cycle end-of-pass pulse
//   err, err_idx/code  sticky abort flag, failing entry, 01=NACK 10=mismatch
module i2c_reg_seq #(
    parameter logic [6:0]  DEV_ADDR  = 7'h76,
    parameter int          NUM_REGS  = 8,
    parameter int          IDX_W     = 4,
    parameter logic [15:0] PRESCALE  = 16'h00FF,
    parameter int          MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             verify_en,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic [2:0]       wb_adr_o,
    output logic [7:0]       wb_dat_o,
    input  logic [7:0]       wb_dat_i,
    output logic             wb_we_o,
    output logic             wb_stb_o,
    input  logic             wb_ack_i,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx,
    output logic [1:0]       err_code
);

    localparam int              RW      = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [RW-1:0]   MAX_R   = RW'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_REGS - 1);

    // Core register addresses
    localparam logic [2:0] A_PRER_LO = 3'd0;
    localparam logic [2:0] A_PRER_HI = 3'd1;
    localparam logic [2:0] A_CTR     = 3'd2;
    localparam logic [2:0] A_TXR_RXR = 3'd3;
    localparam logic [2:0] A_CR_SR   = 3'd4;

    typedef enum logic [3:0] {
        S_RST, S_PRER_LO, S_PRER_HI, S_CTR, S_IDLE, S_FETCH_A, S_FETCH_D,
        S_TXR, S_CR, S_SR_DUMMY, S_SR_POLL, S_RXR, S_STO, S_STO_POLL, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             gap_q, gap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [2:0]       step_q, step_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             verify_q, verify_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic [1:0]       err_code_q, err_code_d;

    logic [7:0] txr_byte, cr_byte;
    logic       ack, entry_ok, entry_fail;
    logic [1:0] fail_code;

    // Byte-op table for one entry. Steps 0-2 are the write phase, 3-6 the
    // read-back phase; step 6 is the read byte and has no TXR write.
    always_comb begin
        txr_byte = {DEV_ADDR, 1'b0};
        cr_byte  = 8'h90;
        case (step_q)
            3'd1, 3'd4: begin txr_byte = addr_q;            cr_byte = 8'h10; end
            3'd2:       begin txr_byte = data_q;            cr_byte = 8'h50; end
            3'd5:       begin txr_byte = {DEV_ADDR, 1'b1};  cr_byte = 8'h90; end
            3'd6:       begin txr_byte = 8'h00;             cr_byte = 8'h68; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        step_d     = step_q;
        addr_d     = addr_q;
        data_d     = data_q;
        verify_d   = verify_q;
        err_d      = err_q;
        err_idx_d  = err_idx_q;
        err_code_d = err_code_q;
        wb_adr_o   = 3'd0;
        wb_dat_o   = 8'h00;
        wb_we_o    = 1'b0;
        entry_ok   = 1'b0;
        entry_fail = 1'b0;
        fail_code  = 2'b00;

        // Every access state holds its strobe until ack; gap_q forces one
        // idle cycle after each completed access (including repeated polls).
        wb_stb_o = (state_q inside {S_PRER_LO, S_PRER_HI, S_CTR, S_TXR, S_CR,
                                    S_SR_DUMMY, S_SR_POLL, S_RXR, S_STO,
                                    S_STO_POLL}) && !gap_q;
        ack      = wb_stb_o && wb_ack_i;
        gap_d    = ack;

        case (state_q)
            S_RST: state_d = S_PRER_LO;
            S_PRER_LO: begin
                wb_adr_o = A_PRER_LO; wb_dat_o = PRESCALE[7:0]; wb_we_o = 1'b1;
                if (ack) state_d = S_PRER_HI;
            end
            S_PRER_HI: begin
                wb_adr_o = A_PRER_HI; wb_dat_o = PRESCALE[15:8]; wb_we_o = 1'b1;
                if (ack) state_d = S_CTR;
            end
            S_CTR: begin
                wb_adr_o = A_CTR; wb_dat_o = 8'h80; wb_we_o = 1'b1;
                if (ack) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (start) begin
                    verify_d   = verify_en;
                    err_d      = 1'b0;
                    err_idx_d  = '0;
                    err_code_d = 2'b00;
                    idx_d      = '0;
                    retry_d    = '0;
                    state_d    = S_FETCH_A;
                end
            end
            S_FETCH_A: state_d = S_FETCH_D;
            S_FETCH_D: begin
                addr_d  = rom_data[15:8];
                data_d  = rom_data[7:0];
                step_d  = 3'd0;
                state_d = S_TXR;
            end
            S_TXR: begin
                wb_adr_o = A_TXR_RXR; wb_dat_o = txr_byte; wb_we_o = 1'b1;
                if (ack) state_d = S_CR;
            end
            S_CR: begin
                wb_adr_o = A_CR_SR; wb_dat_o = cr_byte; wb_we_o = 1'b1;
                if (ack) state_d = S_SR_DUMMY;
            end
            // TIP is not guaranteed valid on the first SR read after CR.
            S_SR_DUMMY: begin
                wb_adr_o = A_CR_SR;
                if (ack) state_d = S_SR_POLL;
            end
            S_SR_POLL: begin
                wb_adr_o = A_CR_SR;
                if (ack && !wb_dat_i[1]) begin
                    if (cr_byte[4] && wb_dat_i[7]) begin
                        state_d = S_STO;
                    end else if (step_q == 3'd6) begin
                        state_d = S_RXR;
                    end else if (step_q == 3'd2 && !verify_q) begin
                        entry_ok = 1'b1;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = (step_q == 3'd5) ? S_CR : S_TXR;
                    end
                end
            end
            S_RXR: begin
                wb_adr_o = A_TXR_RXR;
                if (ack) begin
                    if (wb_dat_i == data_q) begin
                        entry_ok = 1'b1;
                    end else begin
                        // The read byte carried STO, so the bus is already free.
                        entry_fail = 1'b1;
                        fail_code  = 2'b10;
                    end
                end
            end
            S_STO: begin
                wb_adr_o = A_CR_SR; wb_dat_o = 8'h40; wb_we_o = 1'b1;
                if (ack) state_d = S_STO_POLL;
            end
            S_STO_POLL: begin
                wb_adr_o = A_CR_SR;
                if (ack && !wb_dat_i[1]) begin
                    entry_fail = 1'b1;
                    fail_code  = 2'b01;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_RST;
        endcase

        if (entry_ok) begin
            retry_d = '0;
            if (idx_q == LAST) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_FETCH_A;
            end
        end

        // An entry is re-attempted from its write phase; the latched table
        // word is reused, so no refetch is needed.
        if (entry_fail) begin
            if (retry_q >= MAX_R) begin
                err_d      = 1'b1;
                err_idx_d  = idx_q;
                err_code_d = fail_code;
                state_d    = S_DONE;
            end else begin
                retry_d = retry_q + RW'(1);
                step_d  = 3'd0;
                state_d = S_TXR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RST;
            gap_q      <= 1'b0;
            idx_q      <= '0;
            retry_q    <= '0;
            step_q     <= 3'd0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            verify_q   <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            step_q     <= step_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            verify_q   <= verify_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
            err_code_q <= err_code_d;
        end
    end

    assign rom_addr = idx_q;
    assign busy     = !(state_q inside {S_RST, S_IDLE});
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign err_idx  = err_idx_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: a Wishbone I2C-core model (2-cycle ack, TIP held for
// two SR reads after each command) plus a byte-level slave with a register
// memory, injectable NACKs on one register address and a corrupted read-back.
module tb_i2c_reg_seq;
    localparam int         IDX_W    = 4;
    localparam logic [7:0] NACK_REG = 8'h23;
    localparam logic [7:0] BAD_REG  = 8'h25;

    logic             clk = 1'b0;
    logic             reset, start, verify_en;
    logic [IDX_W-1:0] rom_addr;
    logic [15:0]      rom_data;
    logic [2:0]       wb_adr_o;
    logic [7:0]       wb_dat_o, wb_dat_i;
    logic             wb_we_o, wb_stb_o, wb_ack_i;
    logic             busy, done, err;
    logic [IDX_W-1:0] err_idx;
    logic [1:0]       err_code;

    always #5 clk = ~clk;

    i2c_reg_seq dut (
        .clk(clk), .reset(reset), .start(start), .verify_en(verify_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx), .err_code(err_code)
    );

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } acc_t;

    acc_t  log_q[$];
    acc_t  exp_q[$];
    logic [15:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr[2:0]];

    // Core + slave model
    int         nack_seen = 0, nack_limit = 0;
    logic       bad_en = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] txr_reg = 8'h00, rxr_reg = 8'h00, cur_reg = 8'h00;
    logic       rxack;
    int         tip_cnt, pos;
    logic [1:0] wcnt;

    assign wb_dat_i = (wb_adr_o == 3'd4) ? {rxack, 5'b00000, (tip_cnt > 0), 1'b0} : rxr_reg;

    always @(posedge clk) begin : bfm
        int   p;
        logic nk;
        if (reset) begin
            wb_ack_i <= 1'b0; wcnt <= 2'd0; tip_cnt <= 0; pos <= 0; rxack <= 1'b0;
        end else begin
            wb_ack_i <= 1'b0;
            if (wb_stb_o && !wb_ack_i) begin
                if (wcnt == 2'd1) begin wb_ack_i <= 1'b1; wcnt <= 2'd0; end
                else wcnt <= wcnt + 2'd1;
            end else wcnt <= 2'd0;
            if (wb_stb_o && wb_ack_i) begin
                log_q.push_back(acc_t'{wb_we_o, wb_adr_o, wb_dat_o});
                if (wb_we_o && wb_adr_o == 3'd3) txr_reg <= wb_dat_o;
                if (wb_we_o && wb_adr_o == 3'd4) begin
                    if (wb_dat_o[7:4] != 4'h0) tip_cnt <= 2;
                    if (wb_dat_o[4]) begin
                        p  = wb_dat_o[7] ? 0 : pos;
                        nk = 1'b0;
                        if (p == 1) begin
                            cur_reg <= txr_reg;
                            if (nack_seen < nack_limit && txr_reg == NACK_REG) begin
                                nk = 1'b1;
                                nack_seen <= nack_seen + 1;
                            end
                        end
                        if (p == 2) mem[cur_reg] <= txr_reg;
                        rxack <= nk;
                        pos   <= p + 1;
                    end else if (wb_dat_o[5]) begin
                        rxr_reg <= mem[cur_reg] + ((bad_en && cur_reg == BAD_REG) ? 8'd1 : 8'd0);
                    end
                end
                if (!wb_we_o && wb_adr_o == 3'd4 && tip_cnt > 0) tip_cnt <= tip_cnt - 1;
            end
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic build_exp(input bit ver);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(acc_t'{1'b1, 3'd3, 8'hEC});
            exp_q.push_back(acc_t'{1'b1, 3'd4, 8'h90});
            exp_q.push_back(acc_t'{1'b1, 3'd3, rom[i][15:8]});
            exp_q.push_back(acc_t'{1'b1, 3'd4, 8'h10});
            exp_q.push_back(acc_t'{1'b1, 3'd3, rom[i][7:0]});
            exp_q.push_back(acc_t'{1'b1, 3'd4, 8'h50});
            if (ver) begin
                exp_q.push_back(acc_t'{1'b1, 3'd3, 8'hEC});
                exp_q.push_back(acc_t'{1'b1, 3'd4, 8'h90});
                exp_q.push_back(acc_t'{1'b1, 3'd3, rom[i][15:8]});
                exp_q.push_back(acc_t'{1'b1, 3'd4, 8'h10});
                exp_q.push_back(acc_t'{1'b1, 3'd3, 8'hED});
                exp_q.push_back(acc_t'{1'b1, 3'd4, 8'h90});
                exp_q.push_back(acc_t'{1'b1, 3'd4, 8'h68});
            end
        end
    endtask

    // Reports the 1-based position of the first write that differs (0 = none).
    task automatic chk_seq(input string nm, input int base);
        acc_t w[$];
        int   first;
        for (int k = base; k < log_q.size(); k++) if (log_q[k].we) w.push_back(log_q[k]);
        first = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (first == 0 && (k >= w.size() || w[k] !== exp_q[k])) first = k + 1;
        if (first == 0 && w.size() != exp_q.size()) first = exp_q.size() + 1;
        chk(nm, first, 0);
    endtask

    task automatic chk_init(input string nm, input int base);
        acc_t e [3];
        acc_t a;
        e[0] = acc_t'{1'b1, 3'd0, 8'hFF};
        e[1] = acc_t'{1'b1, 3'd1, 8'h00};
        e[2] = acc_t'{1'b1, 3'd2, 8'h80};
        chk({nm, "_cnt"}, log_q.size() - base, 3);
        for (int k = 0; k < 3; k++) begin
            a = (log_q.size() > base + k) ? log_q[base + k] : acc_t'(12'h000);
            chk($sformatf("%s_w%0d", nm, k), a, e[k]);
        end
    endtask

    task automatic wait_init_done(input string nm, input int base);
        int cyc;
        for (cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            if (!busy && log_q.size() - base >= 3) break;
        end
        if (cyc >= 500) chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic run_pass(input bit ver, input int mid_idx, input bit start_on_done,
                            output int ndone);
        int               cyc;
        bit               poked, chk_next;
        logic [IDX_W-1:0] held;
        @(negedge clk);
        verify_en = ver; start = 1'b1;
        ndone = 0; poked = 0; chk_next = 0; held = '0;
        for (cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            start = 1'b0; verify_en = 1'b0;
            if (chk_next) begin
                chk("mid_start_idx", rom_addr, held);
                chk("mid_start_busy", busy, 1);
                chk_next = 0;
            end
            if (done) begin
                ndone++;
                if (start_on_done) start = 1'b1;
            end else if (!busy) break;
            if (mid_idx >= 0 && !poked && rom_addr == IDX_W'(mid_idx) && wb_stb_o &&
                !wb_ack_i && wb_adr_o == 3'd4 && !wb_we_o) begin
                held = rom_addr; start = 1'b1; poked = 1; chk_next = 1;
            end
        end
        if (cyc >= 20000) chk("pass_timeout", 1, 0);
    endtask

    typedef struct {
        bit         ver;
        int         nacks;
        bit         bad;
        int         exp_wr;
        int         exp_cr40;
        int         exp_rxr;
        bit         exp_err;
        logic [3:0] exp_idx;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int base, base2, nd, nwr, ncr40, nrxr, hi, found, seen_sr, cyc;

        vecs[0] = '{0, 0, 0,  48, 0, 0, 0, 4'd0, 2'b00};
        vecs[1] = '{1, 0, 0, 104, 0, 8, 0, 4'd0, 2'b00};
        vecs[2] = '{0, 2, 0,  58, 2, 0, 0, 4'd0, 2'b00};
        vecs[3] = '{1, 0, 1, 117, 0, 9, 1, 4'd5, 2'b10};
        for (int i = 0; i < 8; i++) rom[i] = {8'h20 + 8'(i), 8'h5A + 8'(i * 8'h11)};

        reset = 1'b1; start = 1'b0; verify_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_dat", {wb_adr_o, wb_dat_o}, 0);
        base = log_q.size();
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("init_busy", busy, 1);
        wait_init_done("init", base);
        chk_init("init", base);
        base2 = log_q.size();
        repeat (30) @(negedge clk);
        chk("init_quiet", log_q.size() - base2, 0);
        chk("init_idle_busy", busy, 0);

        for (int v = 0; v < 4; v++) begin
            nack_limit = nack_seen + vecs[v].nacks;
            bad_en     = vecs[v].bad;
            base       = log_q.size();
            run_pass(vecs[v].ver, -1, 0, nd);
            base2 = log_q.size();
            repeat (30) @(negedge clk) if (done) nd++;
            chk($sformatf("v%0d_quiet", v), log_q.size() - base2, 0);
            nwr = 0; ncr40 = 0; nrxr = 0; hi = 0;
            for (int k = base; k < log_q.size(); k++) begin
                if (log_q[k].we) nwr++;
                if (log_q[k].we && log_q[k].adr == 3'd4 && log_q[k].dat == 8'h40) ncr40++;
                if (!log_q[k].we && log_q[k].adr == 3'd3) nrxr++;
                if (log_q[k].we && log_q[k].adr == 3'd3 &&
                    (log_q[k].dat == 8'h26 || log_q[k].dat == 8'h27)) hi++;
            end
            chk($sformatf("v%0d_done_cnt", v), nd, 1);
            chk($sformatf("v%0d_busy", v), busy, 0);
            chk($sformatf("v%0d_writes", v), nwr, vecs[v].exp_wr);
            chk($sformatf("v%0d_stops", v), ncr40, vecs[v].exp_cr40);
            chk($sformatf("v%0d_rxr_reads", v), nrxr, vecs[v].exp_rxr);
            chk($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            chk($sformatf("v%0d_err_idx", v), err_idx, vecs[v].exp_idx);
            chk($sformatf("v%0d_err_code", v), err_code, vecs[v].exp_code);
            if (vecs[v].bad) chk($sformatf("v%0d_late_entries", v), hi, 0);
            if (vecs[v].nacks == 0 && !vecs[v].bad) begin
                build_exp(vecs[v].ver);
                chk_seq($sformatf("v%0d_write_seq", v), base);
            end
        end
        bad_en = 1'b0;
        nack_limit = nack_seen;

        // start mid-pass and on the done cycle are both ignored; new pass clears err
        base = log_q.size();
        run_pass(1'b0, 3, 1'b1, nd);
        base2 = log_q.size();
        repeat (30) @(negedge clk) if (done) nd++;
        chk("ign_quiet", log_q.size() - base2, 0);
        chk("ign_busy", busy, 0);
        chk("ign_done_cnt", nd, 1);
        chk("ign_err_cleared", err, 0);
        chk("ign_err_code_cleared", err_code, 0);
        build_exp(1'b0);
        chk_seq("ign_write_seq", base);

        // reset during a TIP poll of entry 2
        @(negedge clk);
        verify_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0; seen_sr = 0;
        for (cyc = 0; cyc < 5000; cyc++) begin
            if (rom_addr == 4'd2 && wb_stb_o && wb_adr_o == 3'd4 && !wb_we_o) begin
                if (wb_ack_i) seen_sr = 1;
                else if (seen_sr) begin found = 1; break; end
            end
            @(negedge clk);
        end
        chk("rstpoll_found", found, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstpoll_stb", wb_stb_o, 0);
        chk("rstpoll_rom_addr", rom_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        base = log_q.size();
        wait_init_done("reinit", base);
        chk_init("reinit", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
